// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared single-port synchronous memory.
// CPU and debug requesters each run a req/ack handshake; one memory strobe per transaction.
module mem_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StAck} state_e;

  // Wait counter only needs to reach RD_LAT-1 (at most 3).
  localparam logic [1:0] CntLoad = 2'(RD_LAT - 1);

  state_e          r_state;
  state_e          w_state_next;
  logic            r_owner_dbg;     // owner of the current transaction: 1 = DBG
  logic            r_last_dbg;      // last grant went to DBG
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [1:0]      r_cnt;
  logic [DW-1:0]   r_cpu_rdata;
  logic [DW-1:0]   r_dbg_rdata;
  logic            w_any_req;
  logic            w_grant_dbg;

  // Round-robin pick: on a tie, grant whoever did not win last time.
  always_comb begin
    w_any_req   = cpu_req | dbg_req;
    w_grant_dbg = dbg_req & (~cpu_req | ~r_last_dbg);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic and memory/handshake strobes.
  always_comb begin
    w_state_next = r_state;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    cpu_ack      = 1'b0;
    dbg_ack      = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (w_any_req) w_state_next = StAccess;
      end
      StAccess: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        w_state_next = r_we ? StAck : StWait;
      end
      StWait: begin
        if (r_cnt == 2'd0) w_state_next = StAck;
      end
      StAck: begin
        cpu_ack      = ~r_owner_dbg;
        dbg_ack      = r_owner_dbg;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Grant latch, wait counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_dbg <= 1'b0;
      r_last_dbg  <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (r_state == StIdle && w_any_req) begin
        r_owner_dbg <= w_grant_dbg;
        r_last_dbg  <= w_grant_dbg;
        r_we        <= w_grant_dbg ? dbg_we    : cpu_we;
        r_addr      <= w_grant_dbg ? dbg_addr  : cpu_addr;
        r_wdata     <= w_grant_dbg ? dbg_wdata : cpu_wdata;
      end
      if (r_state == StAccess) r_cnt <= CntLoad;
      if (r_state == StWait) begin
        if (r_cnt == 2'd0) begin
          if (r_owner_dbg) r_dbg_rdata <= mem_rdata;
          else             r_cpu_rdata <= mem_rdata;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end
    end
  end

  // Address/data hold their last latched values outside ACCESS.
  always_comb begin
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    cpu_rdata = r_cpu_rdata;
    dbg_rdata = r_dbg_rdata;
    cpu_stall = cpu_req & ~cpu_ack;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RD_LAT=1 instance with a scoreboard, RD_LAT=3 instance.
module tb_mem_arbiter;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  exp_t exp_q[$];
  logic [31:0] exp_cpu_rd = '0;
  logic [31:0] exp_dbg_rd = '0;

  // RD_LAT=1 instance signals
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, busy;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  // RD_LAT=3 instance signals
  logic        c3_req = 0, c3_we = 0, d3_req = 0, d3_we = 0;
  logic [31:0] c3_addr = '0, c3_wdata = '0, d3_addr = '0, d3_wdata = '0;
  logic        c3_ack, c3_stall, d3_ack, m3_en, m3_we, busy3;
  logic [31:0] c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
    .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata),
    .dbg_ack(d3_ack), .dbg_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .busy(busy3)
  );

  // RD_LAT=1 memory; poison value whenever no read was strobed last cycle.
  logic [31:0] mem1 [0:255];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr[7:0]] : 32'hBAD0BAD0;
  end

  // RD_LAT=3 read-only memory as a 3-stage delay line.
  function automatic logic [31:0] rom3(input logic [31:0] a);
    if (a == 32'h20) return 32'h12345678;
    if (a == 32'h21) return 32'hA5A5A5A5;
    return a ^ 32'h5A5A0000;
  endfunction
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    p3[0] <= (m3_en && !m3_we) ? rom3(m3_addr) : 32'hBAD0BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m3_rdata = p3[2];

  // Scoreboard monitor for the RD_LAT=1 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_en) begin
          en_cnt++;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mem_en_unexpected: got mem_en=1 required no strobe");
          end else begin
            e = exp_q[0];
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
              n_fail++;
              $display("FAIL mem_strobe: got we=%0b addr=%h wdata=%h required we=%0b addr=%h data=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
          end
        end
        if (cpu_ack || dbg_ack) begin
          n_tests++;
          if (cpu_ack && dbg_ack) begin
            n_fail++;
            $display("FAIL ack_overlap: got both acks high required one");
          end
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected: got cpu_ack=%0b dbg_ack=%0b required none", cpu_ack,
                     dbg_ack);
          end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (dbg_ack !== e.dbg || en_cnt !== 1) begin
              n_fail++;
              $display("FAIL ack_owner: got dbg_ack=%0b strobes=%0d required dbg_ack=%0b strobes=1",
                       dbg_ack, en_cnt, e.dbg);
            end
            if (!e.we) begin
              if (e.dbg) exp_dbg_rd = e.data;
              else       exp_cpu_rd = e.data;
            end
            n_tests++;
            if (cpu_rdata !== exp_cpu_rd || dbg_rdata !== exp_dbg_rd) begin
              n_fail++;
              $display("FAIL ack_rdata: got cpu=%h dbg=%h required cpu=%h dbg=%h", cpu_rdata,
                       dbg_rdata, exp_cpu_rd, exp_dbg_rd);
            end
          end
          en_cnt = 0;
        end
      end
    end
  end

  // Single transaction on the RD_LAT=1 instance; lat counts cycles after the sampling edge.
  task automatic txn(input bit dbg, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, output int lat, output bit stall_ok);
    exp_t e;
    e.dbg = dbg; e.we = we; e.addr = addr; e.data = we ? wdata : exp_rd;
    @(posedge clk); #1;
    if (dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    exp_q.push_back(e);
    lat = -1;
    stall_ok = 1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (dbg ? dbg_ack : cpu_ack) begin
        lat = n;
        if (!dbg && cpu_stall !== 1'b0) stall_ok = 0;
        break;
      end
      if (!dbg && cpu_stall !== 1'b1) stall_ok = 0;
    end
    @(posedge clk); #1;
    if (dbg) dbg_req = 0; else cpu_req = 0;
  endtask

  // Both requesters active; each drops req after its n-th ack. Records first-ack cycle indices.
  task automatic run_both(input int n_cpu, input int n_dbg, output int got, output int t_cpu,
                          output int t_dbg);
    int ca = 0;
    int da = 0;
    t_cpu = -1;
    t_dbg = -1;
    for (int c = 0; c < 200 && (ca < n_cpu || da < n_dbg); c++) begin
      @(negedge clk);
      if (cpu_ack) begin ca++; if (t_cpu < 0) t_cpu = c; end
      if (dbg_ack) begin da++; if (t_dbg < 0) t_dbg = c; end
      @(posedge clk); #1;
      if (ca >= n_cpu) cpu_req = 0;
      if (da >= n_dbg) dbg_req = 0;
    end
    got = ca + da;
  endtask

  task automatic push(input bit dbg, input bit we, input logic [31:0] addr, input logic [31:0] d);
    exp_t e;
    e.dbg = dbg; e.we = we; e.addr = addr; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    int got, tc, td;
    rst = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wdata = 32'h11111111;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h5; dbg_wdata = 32'h22222222;
    push(0, 1, 32'h4, 32'h11111111);
    push(1, 1, 32'h5, 32'h22222222);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (mem_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem: got mem_en=%0b busy=%0b required 0 0", mem_en, busy);
    end
    n_tests++;
    if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: got cpu_ack=%0b dbg_ack=%0b required 0 0", cpu_ack, dbg_ack);
    end
    rst = 0;
    run_both(1, 1, got, tc, td);
    n_tests++;
    if (got !== 2 || !(tc >= 0 && td > tc)) begin
      n_fail++;
      $display("FAIL reset_first_grant: got acks=%0d t_cpu=%0d t_dbg=%0d required 2, cpu first",
               got, tc, td);
    end
  endtask

  task automatic test_cpu_write_read();
    int lat;
    bit st;
    txn(0, 1, 32'h10, 32'hDEADBEEF, '0, lat, st);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL cpu_write_latency: got %0d required 2", lat);
    end
    txn(0, 0, 32'h10, '0, 32'hDEADBEEF, lat, st);
    n_tests++;
    if (lat !== 3 || !st) begin
      n_fail++;
      $display("FAIL cpu_read_latency: got lat=%0d stall_ok=%0b required 3 1", lat, st);
    end
    n_tests++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL cpu_read_data: got %h required deadbeef", cpu_rdata);
    end
  endtask

  task automatic test_pending();
    int got, tc, td;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    push(0, 0, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk); #1;
    // CPU read is now in WAIT
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hCAFEF00D;
    push(1, 1, 32'h40, 32'hCAFEF00D);
    run_both(1, 1, got, tc, td);
    n_tests++;
    if (got !== 2 || td - tc !== 3) begin
      n_fail++;
      $display("FAIL pending_grant: got acks=%0d gap=%0d required 2 3", got, td - tc);
    end
  endtask

  task automatic test_contention();
    int got, tc, td;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA0001;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h31; dbg_wdata = 32'hBBBB0002;
    for (int i = 0; i < 2; i++) begin
      push(0, 1, 32'h30, 32'hAAAA0001);
      push(1, 1, 32'h31, 32'hBBBB0002);
    end
    run_both(2, 2, got, tc, td);
    n_tests++;
    if (got !== 4 || td - tc !== 3) begin
      n_fail++;
      $display("FAIL contention: got acks=%0d gap=%0d required 4 3", got, td - tc);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, acks;
    bit st;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    push(0, 0, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    cpu_req = 0;
    @(negedge clk);
    exp_q.delete();
    en_cnt = 0;
    exp_cpu_rd = '0;
    exp_dbg_rd = '0;
    n_tests++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 32'h0 || busy !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait_state: got ack=%0b rdata=%h busy=%0b mem_en=%0b required 0 0 0 0",
               cpu_ack, cpu_rdata, busy, mem_en);
    end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack || mem_en) acks++;
    end
    n_tests++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL reset_wait_quiet: got %0d activity cycles required 0", acks);
    end
    txn(0, 0, 32'h10, '0, 32'hDEADBEEF, lat, st);
    n_tests++;
    if (lat !== 3 || cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reset_wait_recover: got lat=%0d rdata=%h required 3 deadbeef", lat, cpu_rdata);
    end
  endtask

  task automatic txn3(input bit dbg, input logic [31:0] addr, output int lat);
    @(posedge clk); #1;
    if (dbg) begin d3_req = 1; d3_addr = addr; end
    else     begin c3_req = 1; c3_addr = addr; end
    lat = -1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (dbg ? d3_ack : c3_ack) begin lat = n; break; end
    end
    @(posedge clk); #1;
    d3_req = 0;
    c3_req = 0;
  endtask

  task automatic test_rd_lat3();
    int lat;
    txn3(0, 32'h21, lat);
    n_tests++;
    if (lat !== 5 || c3_rdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL lat3_cpu_read: got lat=%0d rdata=%h required 5 a5a5a5a5", lat, c3_rdata);
    end
    txn3(1, 32'h20, lat);
    n_tests++;
    if (lat !== 5 || d3_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL lat3_dbg_read: got lat=%0d rdata=%h required 5 12345678", lat, d3_rdata);
    end
    n_tests++;
    if (c3_rdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL lat3_cpu_rdata_kept: got %h required a5a5a5a5", c3_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_pending();
    test_contention();
    test_reset_in_wait();
    test_rd_lat3();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
